// File: rtl/ext_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ext_pipe
// Function : Two-stage pipelined immediate extender with valid/ready
//            handshakes on both sides and a synchronous pipeline flush.
// Revision : 1.0  initial release
// ============================================================================
module ext_pipe #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int SHAMT_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  imm,
    input  logic [2:0]        ExtSel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] extout,
    output logic              busy
);

    localparam logic [2:0] c_MODE_ZEXT   = 3'b000;
    localparam logic [2:0] c_MODE_SEXT   = 3'b001;
    localparam logic [2:0] c_MODE_UPPER  = 3'b010;
    localparam logic [2:0] c_MODE_BRANCH = 3'b011;
    localparam logic [2:0] c_MODE_SHAMT  = 3'b100;

    // Stage 1: raw operand capture
    logic              r_s1_valid;
    logic [IMM_W-1:0]  r_s1_imm;
    logic [2:0]        r_s1_sel;

    // Stage 2: extended result, drives extout directly
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_data;

    logic              w_s2_adv;
    logic              w_accept;
    logic              w_out_fire;

    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_upper;
    logic [DATA_W-1:0] w_branch;
    logic [DATA_W-1:0] w_shamt;
    logic [DATA_W-1:0] w_ext;

    assign w_s2_adv   = r_s1_valid && (!r_s2_valid || out_ready);
    assign w_out_fire = r_s2_valid && out_ready;
    // A flush drops the offered entry even though in_ready may read 1.
    assign w_accept   = in_valid && in_ready && !flush;

    assign in_ready  = !r_s1_valid || w_s2_adv;
    assign out_valid = r_s2_valid;
    assign extout    = r_s2_data;
    assign busy      = r_s1_valid || r_s2_valid;

    assign w_zext   = {{(DATA_W-IMM_W){1'b0}}, r_s1_imm};
    assign w_sext   = {{(DATA_W-IMM_W){r_s1_imm[IMM_W-1]}}, r_s1_imm};
    assign w_upper  = {r_s1_imm, {(DATA_W-IMM_W){1'b0}}};
    assign w_branch = w_sext << 2;
    assign w_shamt  = {{(DATA_W-SHAMT_W){1'b0}}, r_s1_imm[SHAMT_W-1:0]};

    always_comb begin
        w_ext = w_zext;
        case (r_s1_sel)
            c_MODE_ZEXT:   w_ext = w_zext;
            c_MODE_SEXT:   w_ext = w_sext;
            c_MODE_UPPER:  w_ext = w_upper;
            c_MODE_BRANCH: w_ext = w_branch;
            c_MODE_SHAMT:  w_ext = w_shamt;
            default:       w_ext = w_zext;
        endcase
    end

    // Valid bits: reset beats flush, flush beats any transfer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
            end else if (w_s2_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s2_adv) begin
                r_s2_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    // Data registers are left untouched by flush; only the valid bits matter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1_imm  <= '0;
            r_s1_sel  <= '0;
            r_s2_data <= '0;
        end else begin
            if (w_accept) begin
                r_s1_imm <= imm;
                r_s1_sel <= ExtSel;
            end
            if (w_s2_adv && !flush) begin
                r_s2_data <= w_ext;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_pipe
// Function : Self-checking bench for ext_pipe: directed scenarios plus a
//            randomized stream against a transaction-level queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ext_pipe;

    localparam int DW  = 32;
    localparam int IW  = 16;
    localparam int DW2 = 24;
    localparam int IW2 = 12;

    logic           CLK = 1'b0;
    logic           RST;
    logic           flush;
    logic           in_valid;
    logic           out_ready;
    logic [IW-1:0]  imm;
    logic [2:0]     ExtSel;
    logic           in_ready;
    logic           out_valid;
    logic           busy;
    logic [DW-1:0]  extout;

    logic           flush2;
    logic           in_valid2;
    logic           out_ready2;
    logic [IW2-1:0] imm2;
    logic [2:0]     ExtSel2;
    logic           in_ready2;
    logic           out_valid2;
    logic           busy2;
    logic [DW2-1:0] extout2;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    ext_pipe #(.DATA_W(DW), .IMM_W(IW), .SHAMT_W(5)) u_dut (
        .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .imm(imm), .ExtSel(ExtSel),
        .out_valid(out_valid), .out_ready(out_ready), .extout(extout),
        .busy(busy)
    );

    ext_pipe #(.DATA_W(DW2), .IMM_W(IW2), .SHAMT_W(5)) u_dut_small (
        .CLK(CLK), .RST(RST), .flush(flush2), .in_valid(in_valid2),
        .in_ready(in_ready2), .imm(imm2), .ExtSel(ExtSel2),
        .out_valid(out_valid2), .out_ready(out_ready2), .extout(extout2),
        .busy(busy2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference extension written directly from the mode definitions.
    function automatic logic [31:0] ref_ext(input logic [IW-1:0] v, input int mode);
        longint u;
        longint s;
        longint r;
        u = longint'(v);
        s = (u >= (64'd1 << (IW - 1))) ? u - (64'd1 << IW) : u;
        case (mode)
            1:       r = s;
            2:       r = u * (64'd1 << (DW - IW));
            3:       r = s * 4;
            4:       r = u % 32;
            default: r = u;
        endcase
        return r[31:0];
    endfunction

    typedef struct {
        logic [31:0] val;
        int          acc;
    } ent_t;

    ent_t q[$];

    initial begin
        logic [2:0]  sweep_mode [6];
        logic [31:0] sweep_exp  [6];
        logic [15:0] bp_val     [3];
        logic [2:0]  var_mode   [3];
        logic [23:0] var_exp    [3];
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic        in_fire;
        logic        out_fire;
        ent_t        e;

        sweep_mode = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        sweep_exp  = '{32'h0000_8004, 32'hFFFF_8004, 32'h8004_0000,
                       32'hFFFE_0010, 32'h0000_0004, 32'h0000_8004};
        bp_val     = '{16'h7FFF, 16'h8000, 16'h0001};
        var_mode   = '{3'd1, 3'd2, 3'd3};
        var_exp    = '{24'hFFF800, 24'h800000, 24'hFFE000};

        RST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        imm = '0; ExtSel = '0;
        flush2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0; imm2 = '0; ExtSel2 = '0;
        tick();
        tick();
        RST = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_extout", extout, 32'h0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);

        // Mode sweep with exact two-cycle latency
        out_ready = 1'b1;
        for (int m = 0; m < 6; m++) begin
            in_valid = 1'b1; imm = 16'h8004; ExtSel = sweep_mode[m];
            #1;
            chk("sweep_in_ready", in_ready, 1'b1);
            tick();
            in_valid = 1'b0;
            chk("sweep_lat1_valid", out_valid, 1'b0);
            tick();
            chk("sweep_lat2_valid", out_valid, 1'b1);
            chk($sformatf("sweep_mode%0d", sweep_mode[m]), extout, sweep_exp[m]);
            tick();
            chk("sweep_drained", out_valid, 1'b0);
        end

        // Streaming: 8 back-to-back sign-extend inputs
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 8);
            imm = 16'(c); ExtSel = 3'd1;
            #1;
            chk("stream_in_ready", in_ready, 1'b1);
            tick();
            chk("stream_out_valid", out_valid, (c >= 1 && c <= 8));
            if (c >= 1 && c <= 8) chk("stream_data", extout, 32'(c - 1));
        end
        in_valid = 1'b0;
        tick();

        // Backpressure: fill both stages, then release
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; imm = bp_val[i]; ExtSel = 3'd1;
            #1;
            chk($sformatf("bp_in_ready_%0d", i), in_ready, (i < 2));
            tick();
        end
        chk("bp_hold_valid", out_valid, 1'b1);
        chk("bp_hold_data", extout, 32'h0000_7FFF);
        tick();
        chk("bp_hold_data2", extout, 32'h0000_7FFF);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("bp_out1_valid", out_valid, 1'b1);
        chk("bp_out1", extout, 32'hFFFF_8000);
        tick();
        chk("bp_out2_valid", out_valid, 1'b1);
        chk("bp_out2", extout, 32'h0000_0001);
        tick();
        chk("bp_empty_valid", out_valid, 1'b0);
        chk("bp_empty_busy", busy, 1'b0);

        // Flush with two entries in flight plus a concurrent offer
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; imm = 16'h1111 * 16'(i + 1); ExtSel = 3'd0;
            tick();
        end
        imm = 16'h3333; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_busy", busy, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_no_output", out_valid, 1'b0);
        end

        // Reset mid-operation
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; imm = 16'hA5A0 + 16'(i); ExtSel = 3'd1;
            tick();
        end
        in_valid = 1'b0; RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        chk("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_extout", extout, 32'h0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_in_ready", in_ready, 1'b1);
        out_ready = 1'b1; in_valid = 1'b1; imm = 16'h1234; ExtSel = 3'd0;
        tick();
        in_valid = 1'b0;
        chk("rst_next_lat1", out_valid, 1'b0);
        tick();
        chk("rst_next_valid", out_valid, 1'b1);
        chk("rst_next_data", extout, 32'h0000_1234);
        tick();

        // Narrow parameter variant
        out_ready2 = 1'b1;
        for (int m = 0; m < 3; m++) begin
            in_valid2 = 1'b1; imm2 = 12'h800; ExtSel2 = var_mode[m];
            tick();
            in_valid2 = 1'b0;
            tick();
            chk("var_valid", out_valid2, 1'b1);
            chk($sformatf("var_mode%0d", var_mode[m]), extout2, var_exp[m]);
            tick();
        end

        // Randomized stream against the queue model
        RST = 1'b1;
        tick();
        RST = 1'b0;
        q.delete();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            imm       = ($urandom_range(0, 1) != 0) ? 16'($urandom) : (16'h8000 | 16'($urandom_range(0, 31)));
            ExtSel    = 3'($urandom_range(0, 7));
            #1;
            exp_in_ready  = (q.size() < 2) || out_ready;
            exp_out_valid = (q.size() > 0) && (q[0].acc + 2 <= cyc);
            chk("rnd_in_ready", in_ready, exp_in_ready);
            chk("rnd_out_valid", out_valid, exp_out_valid);
            chk("rnd_busy", busy, (q.size() > 0));
            if (exp_out_valid) chk("rnd_data", extout, q[0].val);
            in_fire  = in_valid && exp_in_ready && !flush;
            out_fire = exp_out_valid && out_ready;
            e.val = ref_ext(imm, int'(ExtSel));
            e.acc = cyc;
            tick();
            if (flush) begin
                q.delete();
            end else begin
                if (out_fire) void'(q.pop_front());
                if (in_fire) q.push_back(e);
            end
        end
        in_valid = 1'b0; flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
